// File: rtl/pilot_sprite_renderer.sv
// Pixel source for a 1280x800 display: dark-blue background plus a 32x32 sprite
// steered once per frame by four buttons, flashing red for a while after hitting an edge.
module pilot_sprite_renderer #(
   parameter int SCREEN_W     = 1280,
   parameter int SCREEN_H     = 800,
   parameter int SPRITE_W     = 32,
   parameter int SPRITE_H     = 32,
   parameter int STEP         = 4,
   parameter int START_X      = 624,
   parameter int START_Y      = 384,
   parameter int FLASH_FRAMES = 30
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_up,
   input  logic        btn_down,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic [10:0] curr_x,
   input  logic [9:0]  curr_y,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic        frame_tick,
   output logic [10:0] pos_x,
   output logic [9:0]  pos_y,
   output logic        flashing
);
   localparam int CW = $clog2(FLASH_FRAMES + 1);
   localparam logic signed [11:0] STEP_S = 12'(STEP);
   localparam logic signed [11:0] X_MAX  = 12'(SCREEN_W - SPRITE_W);
   localparam logic signed [11:0] Y_MAX  = 12'(SCREEN_H - SPRITE_H);

   typedef enum logic {FLY, FLASH} state_t;

   state_t        r_state, w_state_next;
   logic [10:0]   r_pos_x, w_pos_x_next, w_mv_x;
   logic [9:0]    r_pos_y, w_pos_y_next, w_mv_y;
   logic [CW-1:0] r_cnt, w_cnt_next;
   logic          r_last_px_d, r_frame_tick;
   logic [3:0]    r_red, r_green, r_blue;
   logic [3:0]    w_red, w_green, w_blue;

   logic w_last_px, w_go_l, w_go_r, w_go_u, w_go_d, w_hit;
   logic w_inside, w_border;
   logic signed [11:0] w_x_l, w_x_r, w_y_u, w_y_d;
   logic [11:0] w_dx, w_dy;

   // last_px stays high through blanking, so only its rising edge makes a tick
   assign w_last_px = (curr_x == 11'(SCREEN_W - 1)) && (curr_y == 10'(SCREEN_H - 1));

   assign w_go_l = btn_left  & ~btn_right;
   assign w_go_r = btn_right & ~btn_left;
   assign w_go_u = btn_up    & ~btn_down;
   assign w_go_d = btn_down  & ~btn_up;

   assign w_x_l = $signed({1'b0, r_pos_x}) - STEP_S;
   assign w_x_r = $signed({1'b0, r_pos_x}) + STEP_S;
   assign w_y_u = $signed({2'b00, r_pos_y}) - STEP_S;
   assign w_y_d = $signed({2'b00, r_pos_y}) + STEP_S;

   assign w_hit = (w_go_l && (w_x_l < 12'sd0)) || (w_go_r && (w_x_r > X_MAX)) ||
                  (w_go_u && (w_y_u < 12'sd0)) || (w_go_d && (w_y_d > Y_MAX));

   always_comb begin
      w_mv_x = r_pos_x;
      w_mv_y = r_pos_y;
      if (w_go_l)      w_mv_x = (w_x_l < 12'sd0) ? 11'd0 : w_x_l[10:0];
      else if (w_go_r) w_mv_x = (w_x_r > X_MAX) ? X_MAX[10:0] : w_x_r[10:0];
      if (w_go_u)      w_mv_y = (w_y_u < 12'sd0) ? 10'd0 : w_y_u[9:0];
      else if (w_go_d) w_mv_y = (w_y_d > Y_MAX) ? Y_MAX[9:0] : w_y_d[9:0];
   end

   always_comb begin
      w_state_next = r_state;
      w_pos_x_next = r_pos_x;
      w_pos_y_next = r_pos_y;
      w_cnt_next   = r_cnt;
      if (r_frame_tick) begin
         case (r_state)
            FLY: begin
               w_pos_x_next = w_mv_x;
               w_pos_y_next = w_mv_y;
               if (w_hit) begin
                  w_state_next = FLASH;
                  w_cnt_next   = CW'(FLASH_FRAMES);
               end
            end
            FLASH: begin
               if (r_cnt == CW'(1)) begin
                  w_state_next = FLY;
                  w_cnt_next   = '0;
               end else begin
                  w_cnt_next = r_cnt - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Offsets wrap to large values left of / above the sprite, so one upper bound suffices
   assign w_dx     = {1'b0, curr_x} - {1'b0, r_pos_x};
   assign w_dy     = {2'b00, curr_y} - {2'b00, r_pos_y};
   assign w_inside = (w_dx <= 12'(SPRITE_W - 1)) && (w_dy <= 12'(SPRITE_H - 1));
   assign w_border = (w_dx < 12'd2) || (w_dx > 12'(SPRITE_W - 3)) ||
                     (w_dy < 12'd2) || (w_dy > 12'(SPRITE_H - 3));

   always_comb begin
      w_red   = 4'h0;
      w_green = 4'h0;
      w_blue  = 4'h6;
      if (w_inside) begin
         w_blue = 4'h0;
         w_red  = 4'hF;
         if (r_state == FLY) begin
            w_green = 4'hF;
            w_blue  = w_border ? 4'h0 : 4'hF;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= FLY;
         r_pos_x      <= 11'(START_X);
         r_pos_y      <= 10'(START_Y);
         r_cnt        <= '0;
         r_last_px_d  <= 1'b0;
         r_frame_tick <= 1'b0;
         r_red        <= 4'h0;
         r_green      <= 4'h0;
         r_blue       <= 4'h0;
      end else begin
         r_state      <= w_state_next;
         r_pos_x      <= w_pos_x_next;
         r_pos_y      <= w_pos_y_next;
         r_cnt        <= w_cnt_next;
         r_last_px_d  <= w_last_px;
         r_frame_tick <= w_last_px & ~r_last_px_d;
         r_red        <= w_red;
         r_green      <= w_green;
         r_blue       <= w_blue;
      end
   end

   assign red        = r_red;
   assign green      = r_green;
   assign blue       = r_blue;
   assign frame_tick = r_frame_tick;
   assign pos_x      = r_pos_x;
   assign pos_y      = r_pos_y;
   assign flashing   = (r_state == FLASH);
endmodule

// File: tb/tb_pilot_sprite_renderer.sv
// Bench for pilot_sprite_renderer: two instances (default start and START_X=2) checked
// every cycle against a frame-level behavioural model, plus hand-computed spot checks.
module tb_pilot_sprite_renderer;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, btn_up, btn_down, btn_left, btn_right;
   logic [10:0] curr_x;
   logic [9:0]  curr_y;
   logic [3:0]  red_o [2];
   logic [3:0]  green_o [2];
   logic [3:0]  blue_o [2];
   logic        tick_o [2];
   logic [10:0] pos_x_o [2];
   logic [9:0]  pos_y_o [2];
   logic        flash_o [2];

   pilot_sprite_renderer dut0 (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right), .curr_x(curr_x), .curr_y(curr_y),
      .red(red_o[0]), .green(green_o[0]), .blue(blue_o[0]), .frame_tick(tick_o[0]),
      .pos_x(pos_x_o[0]), .pos_y(pos_y_o[0]), .flashing(flash_o[0])
   );

   pilot_sprite_renderer #(.START_X(2)) dut1 (
      .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down),
      .btn_left(btn_left), .btn_right(btn_right), .curr_x(curr_x), .curr_y(curr_y),
      .red(red_o[1]), .green(green_o[1]), .blue(blue_o[1]), .frame_tick(tick_o[1]),
      .pos_x(pos_x_o[1]), .pos_y(pos_y_o[1]), .flashing(flash_o[1])
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int  m_x [2];
   int  m_y [2];
   int  m_fl [2];        // frames of flashing still to go; 0 means flying
   bit  m_tick [2];
   bit  m_prev [2];
   logic [11:0] m_rgb [2];
   bit  m_valid = 1'b0;
   int  mdx, mdy, mnx, mny;
   bit  mhit, mlast;

   function automatic logic [11:0] pix(input int x, input int y, input int px, input int py,
                                       input bit fl);
      if (x < px || x > px + 31 || y < py || y > py + 31) return 12'h006;
      if (fl) return 12'hF00;
      if (x - px < 2 || px + 31 - x < 2 || y - py < 2 || py + 31 - y < 2) return 12'hFF0;
      return 12'hFFF;
   endfunction

   always @(posedge clk) begin
      mlast = (int'(curr_x) == 1279) && (int'(curr_y) == 799);
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            m_x[i] = (i == 0) ? 624 : 2;
            m_y[i] = 384;
            m_fl[i] = 0;
            m_tick[i] = 1'b0;
            m_prev[i] = 1'b0;
            m_rgb[i] = 12'h000;
         end else begin
            m_rgb[i] = pix(int'(curr_x), int'(curr_y), m_x[i], m_y[i], m_fl[i] != 0);
            if (m_tick[i]) begin
               if (m_fl[i] == 0) begin
                  mdx = (btn_right && !btn_left) ? 4 : (btn_left && !btn_right) ? -4 : 0;
                  mdy = (btn_down && !btn_up) ? 4 : (btn_up && !btn_down) ? -4 : 0;
                  mnx = m_x[i] + mdx;
                  mny = m_y[i] + mdy;
                  mhit = 1'b0;
                  if (mnx < 0)    begin mnx = 0;    mhit = 1'b1; end
                  if (mnx > 1248) begin mnx = 1248; mhit = 1'b1; end
                  if (mny < 0)    begin mny = 0;    mhit = 1'b1; end
                  if (mny > 768)  begin mny = 768;  mhit = 1'b1; end
                  m_x[i] = mnx;
                  m_y[i] = mny;
                  if (mhit) m_fl[i] = 30;
               end else begin
                  m_fl[i] = m_fl[i] - 1;
               end
            end
            m_tick[i] = mlast && !m_prev[i];
            m_prev[i] = mlast;
         end
      end
      if (rst) m_valid = 1'b1;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < 2; i++) begin
            chk($sformatf("rgb[%0d]", i), {20'd0, red_o[i], green_o[i], blue_o[i]}, {20'd0, m_rgb[i]});
            chk($sformatf("frame_tick[%0d]", i), {31'd0, tick_o[i]}, {31'd0, m_tick[i]});
            chk($sformatf("pos_x[%0d]", i), {21'd0, pos_x_o[i]}, m_x[i]);
            chk($sformatf("pos_y[%0d]", i), {22'd0, pos_y_o[i]}, m_y[i]);
            chk($sformatf("flashing[%0d]", i), {31'd0, flash_o[i]}, {31'd0, m_fl[i] != 0});
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_btn(input logic [3:0] b);
      {btn_up, btn_down, btn_left, btn_right} = b;
   endtask

   task automatic rand_pixels(input int n);
      int k, x, y;
      for (int j = 0; j < n; j++) begin
         if ($urandom_range(0, 1) == 1) begin
            k = int'($urandom_range(0, 1));
            x = m_x[k] + int'($urandom_range(0, 39)) - 4;
            y = m_y[k] + int'($urandom_range(0, 39)) - 4;
         end else begin
            x = int'($urandom_range(0, 1279));
            y = int'($urandom_range(0, 798));
         end
         if (x < 0) x = 0;
         if (x > 1279) x = 1279;
         if (y < 0) y = 0;
         if (y > 798) y = 798;
         curr_x = 11'(x);
         curr_y = 10'(y);
         @(negedge clk);
      end
   endtask

   task automatic frame(input int npix);
      rand_pixels(npix);
      curr_x = 11'd1279;
      curr_y = 10'd799;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   int cnt, first;

   initial begin
      rst = 1'b1;
      set_btn(4'b0000);
      curr_x = 11'd0;
      curr_y = 10'd0;
      repeat (3) @(negedge clk);
      chk("reset pos_x[0]", {21'd0, pos_x_o[0]}, 624);
      chk("reset pos_y[0]", {22'd0, pos_y_o[0]}, 384);
      chk("reset pos_x[1]", {21'd0, pos_x_o[1]}, 2);
      chk("reset rgb[0]", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h000);
      chk("reset flashing[0]", {31'd0, flash_o[0]}, 0);
      chk("reset tick[0]", {31'd0, tick_o[0]}, 0);
      rst = 1'b0;

      curr_x = 11'd624; curr_y = 10'd384; @(negedge clk);
      chk("corner pixel", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'hFF0);
      curr_x = 11'd630; curr_y = 10'd390; @(negedge clk);
      chk("interior pixel", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'hFFF);
      curr_x = 11'd0; curr_y = 10'd0; @(negedge clk);
      chk("background pixel", {20'd0, red_o[0], green_o[0], blue_o[0]}, 32'h006);

      set_btn(4'b0001);
      for (int f = 1; f <= 3; f++) begin
         frame(10);
         chk("right pos_x", {21'd0, pos_x_o[0]}, 624 + 4 * f);
         chk("right pos_y", {22'd0, pos_y_o[0]}, 384);
         chk("right flashing", {31'd0, flash_o[0]}, 0);
      end

      set_btn(4'b1011);
      frame(10);
      chk("lr+up pos_x", {21'd0, pos_x_o[0]}, 636);
      chk("lr+up pos_y", {22'd0, pos_y_o[0]}, 380);
      set_btn(4'b0000);

      do_reset();
      set_btn(4'b0010);
      frame(5);
      set_btn(4'b0000);
      chk("edge hit pos_x", {21'd0, pos_x_o[1]}, 0);
      chk("edge hit flashing", {31'd0, flash_o[1]}, 1);
      chk("no hit flashing[0]", {31'd0, flash_o[0]}, 0);
      curr_x = 11'd10; curr_y = 10'd395; @(negedge clk);
      chk("flash pixel", {20'd0, red_o[1], green_o[1], blue_o[1]}, 32'hF00);
      for (int t = 1; t <= 30; t++) begin
         set_btn(4'($urandom_range(0, 15)));
         frame(5);
         chk("flash countdown", {31'd0, flash_o[1]}, (t < 30) ? 1 : 0);
         chk("flash frozen x", {21'd0, pos_x_o[1]}, 0);
         chk("flash frozen y", {22'd0, pos_y_o[1]}, 384);
      end
      set_btn(4'b0000);

      curr_x = 11'd0; curr_y = 10'd0; @(negedge clk);
      curr_x = 11'd1279; curr_y = 10'd799;
      cnt = 0;
      first = -1;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (tick_o[0]) begin
            cnt++;
            if (first < 0) first = k;
         end
      end
      chk("hold tick count", cnt, 1);
      chk("hold tick latency", first, 0);

      do_reset();
      set_btn(4'b0010);
      frame(5);
      set_btn(4'b0000);
      chk("pre-reset flashing", {31'd0, flash_o[1]}, 1);
      curr_x = 11'd0; curr_y = 10'd0; @(negedge clk);
      curr_x = 11'd1279; curr_y = 10'd799; @(negedge clk);
      rst = 1'b1;
      curr_x = 11'd10; curr_y = 10'd395;
      @(negedge clk);
      chk("rst pos_x[1]", {21'd0, pos_x_o[1]}, 2);
      chk("rst flashing[1]", {31'd0, flash_o[1]}, 0);
      chk("rst rgb[1]", {20'd0, red_o[1], green_o[1], blue_o[1]}, 32'h000);
      chk("rst tick[1]", {31'd0, tick_o[1]}, 0);
      rst = 1'b0;

      for (int f = 0; f < 120; f++) begin
         set_btn(4'($urandom_range(0, 15)));
         if ($urandom_range(0, 24) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
         frame(int'($urandom_range(5, 30)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, errors %0d", n_err);
      $fatal(1, "timeout");
   end
endmodule
